// File: rtl/snes_pad_reader_if.sv
// snes_pad_reader_if
//   Bundle of the SNES pad wires and the decoded button state.
//   master : the reader (drives latch/clock and the decoded outputs,
//            receives serial_data from the pad).
//   slave  : the pad side / button consumers.
// Signals
//   serial_data  pad data, low = pressed, asynchronous to the system clock
//   data_latch   pad latch, active high
//   data_clock   pad clock, idles high
//   buttons[15:0] raw frame, bit i = i-th bit shifted in (active-low)
//   keyinput[9:0] GBA KEYINPUT order (active-low)
//   frame_valid  one-cycle pulse when buttons/keyinput update
//   pad_present  last accepted frame looked like a real pad
//   fsm_state    reader state, for observation only
// Handshake: frame_valid is a pure strobe with no ready; consumers may read
//   buttons/keyinput at any time, frame_valid only marks the cycle they change.
interface snes_pad_reader_if;
  logic        serial_data;
  logic        data_latch;
  logic        data_clock;
  logic [15:0] buttons;
  logic [9:0]  keyinput;
  logic        frame_valid;
  logic        pad_present;
  logic [2:0]  fsm_state;

  modport master (
    input  serial_data,
    output data_latch, data_clock, buttons, keyinput,
           frame_valid, pad_present, fsm_state
  );

  modport slave (
    output serial_data,
    input  data_latch, data_clock, buttons, keyinput,
           frame_valid, pad_present, fsm_state
  );
endinterface

// File: rtl/snes_pad_reader.sv
// snes_pad_reader
//   Polls an SNES controller at a fixed rate, shifts in its 16 serial bits
//   and presents them raw (buttons) and in GBA KEYINPUT order (keyinput).
//   All button outputs are active-low (0 = pressed).
// Parameters
//   TICK_CYCLES  clock cycles per pad half-period
//   POLL_CYCLES  clock cycles between frame starts
// Ports
//   clock   system clock
//   rst_b   asynchronous active-low reset
//   pad     snes_pad_reader_if.master (pad wires and decoded outputs)
// Build option
//   PAD_DEBOUNCE_EN : when defined, outputs only change after two consecutive
//   identical frames that differ from the current buttons value. When not
//   defined, every completed frame updates the outputs and pulses frame_valid.
module snes_pad_reader #(
  parameter int TICK_CYCLES = 600,
  parameter int POLL_CYCLES = 1_666_667
) (
  input  logic              clock,
  input  logic              rst_b,
  snes_pad_reader_if.master pad
);

  generate
    if (TICK_CYCLES < 2 || POLL_CYCLES <= 40 * TICK_CYCLES) begin : g_param_check
      $error("snes_pad_reader: need TICK_CYCLES >= 2 and POLL_CYCLES > 40*TICK_CYCLES");
    end
  endgenerate

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SAMPLE = 3'd2,
    S_CLK_LO = 3'd3,
    S_CLK_HI = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic [PW-1:0] poll_q;
  logic [TW-1:0] tick_q;
  logic          half_q;     // second tick of the latch pulse
  logic [3:0]    bit_q;
  logic [15:0]   shreg_q;
  logic          latch_q;
  logic          clk_q;
  logic [15:0]   buttons_q;
  logic [9:0]    keyinput_q;
  logic          valid_q;
  logic          present_q;
`ifdef PAD_DEBOUNCE_EN
  logic [15:0]   prev_q;
`endif

  logic poll_strobe;
  logic tick_end;

  assign poll_strobe = (poll_q == POLL_LAST);
  assign tick_end    = (tick_q == TICK_LAST);

  // L,R,Down,Up,Left,Right,Start,Sel,B,A from the pad's B,Y,Sel,Start,U,D,L,R,A,X,L,R order
  function automatic logic [9:0] to_keyinput(input logic [15:0] b);
    return {b[10], b[11], b[5], b[4], b[6], b[7], b[3], b[2], b[0], b[8]};
  endfunction

  function automatic logic is_present(input logic [15:0] b);
    return (b[15:12] == 4'hF) && (b[11:0] != 12'hFFF);
  endfunction

  // Two-flop synchroniser; idles released (high) like an unplugged pad.
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], pad.serial_data};
  end

  // Free-running poll timer; the wrap cycle is the poll strobe.
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b)           poll_q <= '0;
    else if (poll_strobe) poll_q <= '0;
    else                  poll_q <= poll_q + 1'b1;
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      half_q     <= 1'b0;
      bit_q      <= 4'd0;
      shreg_q    <= 16'hFFFF;
      latch_q    <= 1'b0;
      clk_q      <= 1'b1;
      buttons_q  <= 16'hFFFF;
      keyinput_q <= 10'h3FF;
      valid_q    <= 1'b0;
      present_q  <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
      prev_q     <= 16'hFFFF;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (poll_strobe) begin
            state_q <= S_LATCH;
            latch_q <= 1'b1;
            tick_q  <= '0;
            half_q  <= 1'b0;
          end
        end
        S_LATCH: begin
          if (tick_end) begin
            tick_q <= '0;
            if (half_q) begin
              state_q <= S_SAMPLE;
              latch_q <= 1'b0;
              bit_q   <= 4'd0;
            end else begin
              half_q <= 1'b1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          shreg_q[bit_q] <= sync_q[1];
          if (bit_q == 4'd15) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_CLK_LO;
            clk_q   <= 1'b0;
          end
        end
        S_CLK_LO: begin
          if (tick_end) begin
            tick_q  <= '0;
            state_q <= S_CLK_HI;
            clk_q   <= 1'b1;   // pad shifts its next bit out on this edge
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_CLK_HI: begin
          // Holding a full tick puts the next sample mid-way through data-valid.
          if (tick_end) begin
            tick_q  <= '0;
            bit_q   <= bit_q + 4'd1;
            state_q <= S_SAMPLE;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
`ifdef PAD_DEBOUNCE_EN
          prev_q <= shreg_q;
          if ((shreg_q == prev_q) && (shreg_q != buttons_q)) begin
            buttons_q  <= shreg_q;
            keyinput_q <= to_keyinput(shreg_q);
            present_q  <= is_present(shreg_q);
            valid_q    <= 1'b1;
          end
`else
          buttons_q  <= shreg_q;
          keyinput_q <= to_keyinput(shreg_q);
          present_q  <= is_present(shreg_q);
          valid_q    <= 1'b1;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pad.data_latch  = latch_q;
  assign pad.data_clock  = clk_q;
  assign pad.buttons     = buttons_q;
  assign pad.keyinput    = keyinput_q;
  assign pad.frame_valid = valid_q;
  assign pad.pad_present = present_q;
  assign pad.fsm_state   = state_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
`timescale 1ns/1ps
module tb_snes_pad_reader;
  localparam int TICK = 4;
  localparam int POLL = 400;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_b = 1'b0;
  always #5 clock = ~clock;

  snes_pad_reader_if pad_if();

  snes_pad_reader #(.TICK_CYCLES(TICK), .POLL_CYCLES(POLL)) dut (
    .clock (clock),
    .rst_b (rst_b),
    .pad   (pad_if)
  );

  // ---------------- pad model ----------------
  logic [15:0] pad_word = 16'hFFFF;
  logic [15:0] pad_sr   = 16'hFFFF;
  always @(posedge pad_if.data_latch) pad_sr = pad_word;
  always @(posedge pad_if.data_clock) if (!pad_if.data_latch) pad_sr = {1'b1, pad_sr[15:1]};
  assign pad_if.serial_data = pad_sr[0];

  // ---------------- scoreboard / counters ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int fv_count = 0;
  int lo_cnt   = 0;
  int lo_falls = 0;
  int bad_w    = 0;
  int latch_w  = 0;
  time t_fall = 0, last_rise = 0, prev_rise = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  always @(posedge pad_if.data_latch) begin
    prev_rise = last_rise;
    last_rise = $time;
  end
  always @(negedge pad_if.data_latch) if (rst_b) latch_w = int'(($time - last_rise) / 10);
  always @(negedge pad_if.data_clock) begin
    t_fall = $time;
    lo_falls++;
  end
  always @(posedge pad_if.data_clock) begin
    if (rst_b) begin
      lo_cnt++;
      if (($time - t_fall) != TICK * 10) bad_w++;
    end
  end

  always @(negedge clock) begin
    if (rst_b && pad_if.frame_valid) begin
      fv_count++;
      if (exp_q.size() == 0) check("fv_unexpected", 16'(pad_if.frame_valid), 16'h0);
      else                   check("sb_buttons", pad_if.buttons, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_frame(input logic [15:0] w, input bit upd, output int waited);
    pad_word = w;
    if (upd) exp_q.push_back(w);
    lo_cnt = 0;
    bad_w  = 0;
    waited = 0;
    while (!pad_if.data_latch && waited < 1000) begin
      @(posedge clock); #1;
      waited++;
    end
    if (!pad_if.data_latch) check("latch_timeout", 16'h0, 16'h1);
    repeat (150) @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_latch"},    16'(pad_if.data_latch),  16'h0);
    check({tag, "_clk"},      16'(pad_if.data_clock),  16'h1);
    check({tag, "_buttons"},  pad_if.buttons,          16'hFFFF);
    check({tag, "_keyinput"}, 16'(pad_if.keyinput),    16'h03FF);
    check({tag, "_fv"},       16'(pad_if.frame_valid), 16'h0);
    check({tag, "_present"},  16'(pad_if.pad_present), 16'h0);
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] b, input logic [9:0] k, input logic p);
    check({tag, "_buttons"},  pad_if.buttons,          b);
    check({tag, "_keyinput"}, 16'(pad_if.keyinput),    16'(k));
    check({tag, "_present"},  16'(pad_if.pad_present), 16'(p));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int fv0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    rst_b = 1'b1;

`ifdef PAD_DEBOUNCE_EN
    fv0 = fv_count;
    run_frame(16'hFFFF, 1'b0, w);
    check("first_strobe", 16'(w), 16'd400);
    check("latch_width", 16'(latch_w), 16'(2 * TICK));
    check("clk_pulses", 16'(lo_cnt), 16'd15);
    check("clk_width_bad", 16'(bad_w), 16'd0);
    for (int i = 0; i < 4; i++) run_frame((i % 2 == 0) ? 16'hFFFE : 16'hFFFF, 1'b0, w);
    check("alt_no_update", 16'(fv_count - fv0), 16'd0);
    check_outputs("alt", 16'hFFFF, 10'h3FF, 1'b0);
    run_frame(16'hFFFE, 1'b0, w);
    check("first_fffe_no_update", 16'(fv_count - fv0), 16'd0);
    run_frame(16'hFFFE, 1'b1, w);
    check("second_fffe_update", 16'(fv_count - fv0), 16'd1);
    check_outputs("debounced", 16'hFFFE, 10'h3FD, 1'b1);
`else
    // first frame after reset, unplugged pad
    fv0 = fv_count;
    run_frame(16'hFFFF, 1'b1, w);
    check("first_strobe", 16'(w), 16'd400);
    check("latch_width", 16'(latch_w), 16'(2 * TICK));
    check("clk_pulses", 16'(lo_cnt), 16'd15);
    check("clk_width_bad", 16'(bad_w), 16'd0);
    check("fv_pulses_1", 16'(fv_count - fv0), 16'd1);
    check_outputs("unplugged", 16'hFFFF, 10'h3FF, 1'b0);

    run_frame(16'hFEFE, 1'b1, w);
    check_outputs("b_a", 16'hFEFE, 10'h3FC, 1'b1);
    check("spacing_1", 16'(int'((last_rise - prev_rise) / 10)), 16'd400);

    run_frame(16'hFF0F, 1'b1, w);
    check_outputs("dpad", 16'hFF0F, 10'h30F, 1'b1);
    check("spacing_2", 16'(int'((last_rise - prev_rise) / 10)), 16'd400);

    run_frame(16'hF0FF, 1'b1, w);
    check_outputs("axlr", 16'hF0FF, 10'h0FE, 1'b1);

    // reset in the middle of the 7th clock-low phase
    pad_word = 16'hFEFE;
    lo_falls = 0;
    for (int i = 0; i < 1000 && lo_falls < 7; i++) @(negedge clock);
    check("mid_reset_reached", 16'(lo_falls), 16'd7);
    @(negedge clock);
    rst_b = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(negedge clock);
    rst_b = 1'b1;
    run_frame(16'hFEFE, 1'b1, w);
    check("post_reset_strobe", 16'(w), 16'd400);
    check_outputs("post_reset", 16'hFEFE, 10'h3FC, 1'b1);

    // three identical frames each pulse frame_valid
    fv0 = fv_count;
    for (int i = 0; i < 3; i++) begin
      run_frame(16'hFDFF, 1'b1, w);
      check_outputs("repeat", 16'hFDFF, 10'h3FF, 1'b1);
    end
    check("fv_pulses_3", 16'(fv_count - fv0), 16'd3);
`endif

    check("sb_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
